// File: rtl/char_ctl.sv
// rtl/char_ctl.sv - per-frame sprite position controller: walk, jump arc, screen clamp
module char_ctl #(
    parameter int SCREEN_W  = 1024,
    parameter int GROUND_Y  = 748,
    parameter int RST_HGT   = 26,
    parameter int MOVE_STEP = 4,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [11:0] char_hgt,
    input  logic [11:0] char_lng,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        flip_h,
    output logic        on_ground
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    localparam logic signed [12:0] SCREEN_W_S  = 13'(SCREEN_W);
    localparam logic signed [12:0] GROUND_Y_S  = 13'(GROUND_Y);
    localparam logic signed [12:0] MOVE_STEP_S = 13'(MOVE_STEP);
    localparam logic [5:0]         JUMP_V0_6   = 6'(JUMP_V0);
    localparam logic [5:0]         GRAVITY_6   = 6'(GRAVITY);
    localparam logic [6:0]         MAX_FALL_7  = 7'(MAX_FALL);

    state_t      state, state_n;
    logic        vblnk_q;
    logic        tick_en;
    logic        tick;
    logic [5:0]  vel, vel_n;
    logic        jump_armed, jump_armed_n;
    logic [11:0] pos_x_n, pos_y_n;
    logic        flip_n;

    logic signed [12:0] x_cur, x_try, x_lo, x_hi;
    logic signed [12:0] y_cur, y_hgt, vel_s, y_up, y_dn, y_floor;
    logic [6:0]         vel_sum;
    logic [5:0]         vel_fall;

    // tick_en suppresses a tick in the first cycle after reset even if vblnk is already high
    assign tick = vblnk & ~vblnk_q & tick_en;

    always_comb begin
        state_n      = state;
        vel_n        = vel;
        pos_x_n      = pos_x;
        pos_y_n      = pos_y;
        flip_n       = flip_h;
        jump_armed_n = jump_armed | ~btn_jump;

        x_cur    = $signed({1'b0, pos_x});
        x_lo     = $signed({1'b0, char_lng});
        x_hi     = SCREEN_W_S - x_lo;
        x_try    = x_cur;
        y_cur    = $signed({1'b0, pos_y});
        y_hgt    = $signed({1'b0, char_hgt});
        vel_s    = $signed({7'b0, vel});
        y_up     = y_cur - vel_s;
        vel_sum  = {1'b0, vel} + {1'b0, GRAVITY_6};
        vel_fall = (vel_sum > MAX_FALL_7) ? MAX_FALL_7[5:0] : vel_sum[5:0];
        y_dn     = y_cur + $signed({7'b0, vel_fall});
        y_floor  = GROUND_Y_S - y_hgt;

        if (tick) begin
            if (btn_left ^ btn_right) begin
                x_try  = btn_left ? (x_cur - MOVE_STEP_S) : (x_cur + MOVE_STEP_S);
                flip_n = btn_left;
                // signed compare so a step below column 0 clamps instead of wrapping
                if (x_try < x_lo)
                    pos_x_n = char_lng;
                else if (x_try > x_hi)
                    pos_x_n = x_hi[11:0];
                else
                    pos_x_n = x_try[11:0];
            end

            case (state)
                GROUND: begin
                    if (btn_jump && jump_armed) begin
                        vel_n        = JUMP_V0_6;
                        jump_armed_n = 1'b0;
                        state_n      = RISE;
                    end
                end
                RISE: begin
                    if (y_up < y_hgt) begin
                        pos_y_n = char_hgt;
                        vel_n   = '0;
                        state_n = FALL;
                    end else begin
                        pos_y_n = y_up[11:0];
                        vel_n   = vel - GRAVITY_6;
                        if (vel_n == '0)
                            state_n = FALL;
                    end
                end
                FALL: begin
                    if (y_dn >= y_floor) begin
                        pos_y_n = y_floor[11:0];
                        vel_n   = '0;
                        state_n = GROUND;
                    end else begin
                        pos_y_n = y_dn[11:0];
                        vel_n   = vel_fall;
                    end
                end
                default: state_n = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q    <= 1'b0;
            tick_en    <= 1'b0;
            state      <= GROUND;
            vel        <= '0;
            jump_armed <= 1'b0;
            pos_x      <= 12'(SCREEN_W / 2);
            pos_y      <= 12'(GROUND_Y - RST_HGT);
            flip_h     <= 1'b0;
            on_ground  <= 1'b1;
        end else begin
            vblnk_q    <= vblnk;
            tick_en    <= 1'b1;
            state      <= state_n;
            vel        <= vel_n;
            jump_armed <= jump_armed_n;
            pos_x      <= pos_x_n;
            pos_y      <= pos_y_n;
            flip_h     <= flip_n;
            on_ground  <= (state_n == GROUND);
        end
    end

endmodule

// File: tb/tb_char_ctl.sv
// tb/tb_char_ctl.sv - self-checking bench for char_ctl
module tb_char_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] char_hgt;
    logic [11:0] char_lng;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        flip_h;
    logic        on_ground;

    char_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .char_hgt  (char_hgt),
        .char_lng  (char_lng),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .flip_h    (flip_h),
        .on_ground (on_ground)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        flip;
        logic        gnd;
    } exp_t;

    typedef struct {
        logic [11:0] lng;
        logic        l;
        logic        r;
        int          reps;
        logic [11:0] ex;
        logic        flip;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t mk(input logic [11:0] x, input logic [11:0] y,
                                input logic flip, input logic gnd);
        exp_t e;
        e.x = x; e.y = y; e.flip = flip; e.gnd = gnd;
        return e;
    endfunction

    task automatic check_out(input string name);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (pos_x !== e.x || pos_y !== e.y || flip_h !== e.flip || on_ground !== e.gnd) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d flip=%0b gnd=%0b, want x=%0d y=%0d flip=%0b gnd=%0b",
                     name, pos_x, pos_y, flip_h, on_ground, e.x, e.y, e.flip, e.gnd);
        end
    endtask

    // One frame: vblnk high for one cycle, result sampled at the following negedge
    task automatic do_tick(input logic l, input logic r, input logic j,
                           input bit chk, input exp_t e, input string name);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        btn_jump  = j;
        vblnk     = 1'b1;
        if (chk) sb.push_back(e);
        @(negedge clk);
        vblnk = 1'b0;
        if (chk) check_out(name);
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.push_back(mk(12'd512, 12'd722, 1'b0, 1'b1));
        check_out(name);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 12 rise + 12 fall ticks after a launch at y=722; jump either held or pulsed mid-air
    task automatic run_arc(input bit hold, input string tag);
        int y;
        for (int k = 1; k <= 12; k++) begin
            y = 722 - (12 * k - (k * (k - 1)) / 2);
            do_tick(1'b0, 1'b0, hold ? 1'b1 : (k == 6), 1'b1,
                    mk(12'd512, 12'(y), 1'b0, 1'b0), $sformatf("%s_rise%0d", tag, k));
        end
        for (int k = 1; k <= 12; k++) begin
            y = 644 + (k * (k + 1)) / 2;
            do_tick(1'b0, 1'b0, hold ? 1'b1 : (k == 4), 1'b1,
                    mk(12'd512, 12'(y), 1'b0, k == 12), $sformatf("%s_fall%0d", tag, k));
        end
    endtask

    initial begin
        vecs[0]  = '{12'd19, 1'b0, 1'b0, 10,  12'd512,  1'b0};
        vecs[1]  = '{12'd19, 1'b0, 1'b1, 5,   12'd532,  1'b0};
        vecs[2]  = '{12'd19, 1'b1, 1'b0, 1,   12'd528,  1'b1};
        vecs[3]  = '{12'd19, 1'b1, 1'b1, 3,   12'd528,  1'b1};
        vecs[4]  = '{12'd19, 1'b0, 1'b0, 1,   12'd528,  1'b1};
        vecs[5]  = '{12'd19, 1'b1, 1'b0, 128, 12'd19,   1'b1};
        vecs[6]  = '{12'd19, 1'b0, 1'b1, 1,   12'd23,   1'b0};
        vecs[7]  = '{12'd17, 1'b1, 1'b0, 2,   12'd17,   1'b1};
        vecs[8]  = '{12'd17, 1'b0, 1'b1, 1,   12'd21,   1'b0};
        vecs[9]  = '{12'd19, 1'b1, 1'b0, 1,   12'd19,   1'b1};
        vecs[10] = '{12'd19, 1'b0, 1'b1, 246, 12'd1003, 1'b0};
        vecs[11] = '{12'd19, 1'b0, 1'b1, 1,   12'd1005, 1'b0};
        vecs[12] = '{12'd19, 1'b0, 1'b1, 1,   12'd1005, 1'b0};
        vecs[13] = '{12'd19, 1'b1, 1'b0, 1,   12'd1001, 1'b1};

        rst       = 1'b1;
        vblnk     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_jump  = 1'b0;
        char_hgt  = 12'd26;
        char_lng  = 12'd19;
        repeat (3) @(negedge clk);
        sb.push_back(mk(12'd512, 12'd722, 1'b0, 1'b1));
        check_out("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            char_lng = vecs[i].lng;
            for (int k = 0; k < vecs[i].reps; k++)
                do_tick(vecs[i].l, vecs[i].r, 1'b0, k == vecs[i].reps - 1,
                        mk(vecs[i].ex, 12'd722, vecs[i].flip, 1'b1), $sformatf("vec%0d", i));
        end

        // buttons without vblnk edges must not move anything
        @(negedge clk);
        btn_right = 1'b1;
        btn_jump  = 1'b1;
        repeat (6) @(negedge clk);
        sb.push_back(mk(12'd1001, 12'd722, 1'b1, 1'b1));
        check_out("hold_no_tick");
        btn_right = 1'b0;
        btn_jump  = 1'b0;

        do_reset("reset2");

        do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b0), "launch1");
        run_arc(1'b0, "arc1");

        do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b0), "launch2");
        run_arc(1'b1, "arc2");
        for (int k = 0; k < 3; k++)
            do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b1),
                    $sformatf("held_no_relaunch%0d", k));
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b1), "release");
        do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b0), "launch3");
        run_arc(1'b0, "arc3");

        // ceiling: tall sprite hits char_hgt on the fifth rise tick
        char_hgt = 12'd680;
        do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b0), "ceil_launch");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd710, 1'b0, 1'b0), "ceil_r1");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd699, 1'b0, 1'b0), "ceil_r2");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd689, 1'b0, 1'b0), "ceil_r3");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd680, 1'b0, 1'b0), "ceil_r4");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd680, 1'b0, 1'b0), "ceil_snap");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd68,  1'b0, 1'b1), "ceil_land");
        char_hgt = 12'd26;
        do_reset("reset3");

        // reset in the middle of a jump, with vblnk held high across it
        do_tick(1'b0, 1'b0, 1'b1, 1'b1, mk(12'd512, 12'd722, 1'b0, 1'b0), "mid_launch");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd710, 1'b0, 1'b0), "mid_r1");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd699, 1'b0, 1'b0), "mid_r2");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd689, 1'b0, 1'b0), "mid_r3");
        do_tick(1'b0, 1'b0, 1'b0, 1'b1, mk(12'd512, 12'd680, 1'b0, 1'b0), "mid_r4");
        @(negedge clk);
        rst   = 1'b1;
        vblnk = 1'b1;
        @(negedge clk);
        sb.push_back(mk(12'd512, 12'd722, 1'b0, 1'b1));
        check_out("rst_mid_jump");
        rst       = 1'b0;
        btn_right = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(mk(12'd512, 12'd722, 1'b0, 1'b1));
        check_out("vblnk_high_no_tick");
        vblnk     = 1'b0;
        btn_right = 1'b0;
        @(negedge clk);
        do_tick(1'b0, 1'b1, 1'b0, 1'b1, mk(12'd516, 12'd722, 1'b0, 1'b1), "post_reset_tick");

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
